// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial framing engine.
package serial_frame_pkg;

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} frame_state_t;

  // Largest payload a length field of len_w bits can announce.
  function automatic int unsigned max_len(input int unsigned len_w);
    return (32'd1 << len_w) - 32'd1;
  endfunction

endpackage

// File: rtl/serial_frame_engine_pattern_detector.sv
// Start-pattern detector: shift history of the last PAT_W-1 bits plus a
// combinational compare against the live serial bit.
module pattern_detector
  import serial_frame_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic serIn,
  output logic match
);

  localparam int HW = PAT_W - 1;

  logic [HW-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clr) begin
      hist_d = '0;
    end else if (en) begin
      hist_d = HW'({hist_q, serIn});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign match = en && ({hist_q, serIn} == PATTERN);

endmodule

// File: rtl/serial_frame_engine.sv
// Serial framing engine: hunt for a start pattern, shift in a length field,
// then forward exactly that many payload bits with a qualifying valid.
module serial_frame_engine
  import serial_frame_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               LEN_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic serIn,
  output logic serOut,
  output logic outValid,
  output logic frameDone,
  output logic lenErr,
  output logic busy
);

  localparam int BCW = (LEN_W > 1) ? $clog2(LEN_W) : 1;

  frame_state_t   state_q, state_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0] len_q, len_d, len_shift;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic serOut_q, serOut_d;
  logic outValid_q, outValid_d;
  logic frameDone_q, frameDone_d;
  logic lenErr_q, lenErr_d;
  logic busy_q, busy_d;
  logic match;

  // History is held clear outside HUNT so each new pattern is received fresh.
  pattern_detector #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_detect (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == HUNT),
    .clr  (state_q != HUNT),
    .serIn(serIn),
    .match(match)
  );

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    serOut_d    = 1'b0;
    outValid_d  = 1'b0;
    frameDone_d = 1'b0;
    lenErr_d    = 1'b0;
    len_shift   = LEN_W'({len_q, serIn});
    unique case (state_q)
      HUNT: begin
        if (match) begin
          state_d  = LEN;
          len_d    = '0;
          bitcnt_d = BCW'(LEN_W - 1);
        end
      end
      LEN: begin
        len_d = len_shift;
        if (bitcnt_q == '0) begin
          if (len_shift == '0) begin
            lenErr_d = 1'b1;
            state_d  = HUNT;
          end else begin
            cnt_d   = len_shift;
            state_d = PAYLOAD;
          end
        end else begin
          bitcnt_d = bitcnt_q - BCW'(1);
        end
      end
      PAYLOAD: begin
        serOut_d   = serIn;
        outValid_d = 1'b1;
        cnt_d      = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          frameDone_d = 1'b1;
          state_d     = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      bitcnt_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      serOut_q    <= 1'b0;
      outValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
      lenErr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      serOut_q    <= serOut_d;
      outValid_q  <= outValid_d;
      frameDone_q <= frameDone_d;
      lenErr_q    <= lenErr_d;
      busy_q      <= busy_d;
    end
  end

  assign serOut    = serOut_q;
  assign outValid  = outValid_q;
  assign frameDone = frameDone_q;
  assign lenErr    = lenErr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_frame_engine.sv
// Directed vector bench for serial_frame_engine (PATTERN 1101 and 0101, LEN_W 3).
module tb_serial_frame_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serIn = 1'b0;
  logic serIn2 = 1'b0;
  logic so1, ov1, fd1, le1, bz1;
  logic so2, ov2, fd2, le2, bz2;

  always #5 clk = ~clk;

  serial_frame_engine #(.PAT_W(4), .PATTERN(4'b1101), .LEN_W(3)) u_dut (
    .clk(clk), .rst(rst), .serIn(serIn), .serOut(so1), .outValid(ov1),
    .frameDone(fd1), .lenErr(le1), .busy(bz1)
  );

  serial_frame_engine #(.PAT_W(4), .PATTERN(4'b0101), .LEN_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .serIn(serIn2), .serOut(so2), .outValid(ov2),
    .frameDone(fd2), .lenErr(le2), .busy(bz2)
  );

  // exp = {serOut, outValid, frameDone, lenErr, busy} seen after the edge sampling in
  typedef struct {
    logic       in;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;
  int   rise_q[$];
  int   fd_q[$];

  function automatic void add(input logic i, input logic [4:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %0b expected %0b", name, idx, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input bit sel, input vec_t v, input string tag, input int idx);
    logic [4:0] got;
    @(negedge clk);
    if (sel) serIn2 = v.in;
    else     serIn  = v.in;
    @(posedge clk);
    #1;
    cyc++;
    got = sel ? {so2, ov2, fd2, le2, bz2} : {so1, ov1, fd1, le1, bz1};
    chk({tag, ".serOut"},    idx, got[4], v.exp[4]);
    chk({tag, ".outValid"},  idx, got[3], v.exp[3]);
    chk({tag, ".frameDone"}, idx, got[2], v.exp[2]);
    chk({tag, ".lenErr"},    idx, got[1], v.exp[1]);
    chk({tag, ".busy"},      idx, got[0], v.exp[0]);
    if (!sel) begin
      if (got[3] && !prev_ov) rise_q.push_back(cyc);
      if (got[2]) fd_q.push_back(cyc);
      prev_ov = got[3];
    end
  endtask

  task automatic run_tbl(input bit sel, input string tag);
    for (int i = 0; i < tbl.size(); i++) step(sel, tbl[i], tag, i);
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset.serOut", 0, so1, 1'b0);
    chk("reset.outValid", 0, ov1, 1'b0);
    chk("reset.frameDone", 0, fd1, 1'b0);
    chk("reset.lenErr", 0, le1, 1'b0);
    chk("reset.busy", 0, bz1, 1'b0);
    chk("reset.busy2", 0, bz2, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Basic frame, length 3, payload 1,0,1
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(1, 5'b00001); add(1, 5'b00001);
    add(1, 5'b11001); add(0, 5'b01001); add(1, 5'b11100); add(0, 5'b00000);
    run_tbl(0, "basic");

    // Overlapping 1,1,1,0,1 matches on the fifth bit, length 1
    add(1, 5'b00000); add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(0, 5'b00001); add(1, 5'b00001);
    add(0, 5'b01100); add(0, 5'b00000);
    run_tbl(0, "overlap");

    // Zero length pulses lenErr once, then a length-1 frame forwards 1
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(0, 5'b00001); add(0, 5'b00010);
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(0, 5'b00001); add(1, 5'b00001);
    add(1, 5'b11100); add(0, 5'b00000);
    run_tbl(0, "zerolen");

    // Maximum length 7 with an embedded 1101 inside the payload
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(1, 5'b00001); add(1, 5'b00001); add(1, 5'b00001);
    add(1, 5'b11001); add(1, 5'b11001); add(0, 5'b01001); add(1, 5'b11001);
    add(1, 5'b11001); add(0, 5'b01001); add(1, 5'b11100);
    add(0, 5'b00000); add(0, 5'b00000);
    run_tbl(0, "maxlen");

    // Back-to-back frames: second pattern starts right after frameDone
    rise_q.delete(); fd_q.delete(); prev_ov = 1'b0;
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(0, 5'b00001); add(1, 5'b00001); add(1, 5'b11100);
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(1, 5'b00001); add(0, 5'b00001);
    add(1, 5'b11001); add(0, 5'b01100); add(0, 5'b00000);
    run_tbl(0, "b2b");
    // Gap counts the cycles strictly between frameDone and the next first outValid
    if (rise_q.size() >= 2 && fd_q.size() >= 1)
      chk_int("b2b.gap", rise_q[1] - fd_q[0] - 1, 7);
    else
      chk_int("b2b.frames_seen", rise_q.size(), 2);

    // Reset mid-payload: length 5, drop rst after two payload bits
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(1, 5'b00001); add(0, 5'b00001); add(1, 5'b00001);
    add(1, 5'b11001); add(0, 5'b01001);
    run_tbl(0, "rstmid");
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid.async.serOut", 0, so1, 1'b0);
    chk("rstmid.async.outValid", 0, ov1, 1'b0);
    chk("rstmid.async.frameDone", 0, fd1, 1'b0);
    chk("rstmid.async.lenErr", 0, le1, 1'b0);
    chk("rstmid.async.busy", 0, bz1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Stale payload tail is ignored; a fresh 1101 then opens a length-1 frame
    add(1, 5'b00000); add(1, 5'b00000); add(1, 5'b00000);
    add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(0, 5'b00001); add(1, 5'b00001);
    add(0, 5'b01100); add(0, 5'b00000);
    run_tbl(0, "rstpost");

    // PATTERN 0101: cleared history lets 1,0,1 match on its third bit
    serIn = 1'b0;
    add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(0, 5'b00001); add(1, 5'b00001);
    add(1, 5'b11100);
    add(1, 5'b00000); add(0, 5'b00000); add(1, 5'b00001);
    add(0, 5'b00001); add(1, 5'b00001); add(0, 5'b00001);
    add(1, 5'b11001); add(1, 5'b11100); add(0, 5'b00000);
    run_tbl(1, "lead0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_engine.md
# serial_frame_engine

Parametrised serial framing block, the next generation of the serial-in sequence-detect / count / transmit circuit. It watches a single-bit serial stream for a configurable start pattern and then shifts in a length field. It then forwards exactly that many payload bits to a registered serial output, with `outValid` qualifying each forwarded bit. It sits directly behind the serial input pin and feeds downstream parallelising or checking logic.

## Interface
- `PAT_W`, 4: start-pattern width in bits (2..16).
- `PATTERN`, 4'b1101: start pattern, MSB is the first-received bit.
- `LEN_W`, 3: length-field width in bits (1..8). Maximum payload is 2^LEN_W-1 bits.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `serIn`  in  1: serial data, sampled every rising edge.
- `serOut`  out  1: forwarded payload bit, registered.
- `outValid`  out  1: `serOut` holds a payload bit this cycle.
- `frameDone`  out  1: one-cycle pulse coincident with the last `outValid` of a frame.
- `lenErr`  out  1: one-cycle pulse when a received length field equals 0.
- `busy`  out  1: state is not HUNT, registered.

## Operation
- **States:** HUNT, LEN, PAYLOAD.
- **HUNT**
  - History register `hist` holds the last PAT_W-1 sampled bits and shifts every cycle.
  - A match is `{hist, serIn} == PATTERN`, so overlapping patterns are detected naturally.
  - On a match, go to LEN. The length counter loads 0 and the bit counter loads LEN_W-1.
- **LEN**
  - Shift `serIn` into `len`, MSB first, for exactly LEN_W samples.
  - After the final sample:
    - assembled length = 0: pulse `lenErr`, go to HUNT.
    - otherwise: load the down-counter with the assembled length and go to PAYLOAD.
- **PAYLOAD**
  - Each cycle: `serOut <= serIn`, `outValid <= 1`, counter decrements.
  - On the sample where the counter equals 1: `frameDone <= 1` and go to HUNT.
  - Pattern matching is disabled during payload, so pattern bits inside the payload are ignored.
- **Entering HUNT from LEN or PAYLOAD:** `hist` clears to 0. The next pattern must be received entirely after the frame.
  - Exception: if PATTERN begins with zeros, a cleared `hist` can yield a match after fewer than PAT_W fresh samples. This is accepted behaviour.
- **Outside PAYLOAD:** `serOut` = 0, `outValid` = 0.
- **Reset values:** `serOut`, `outValid`, `frameDone`, `lenErr`, `busy` all 0. State is HUNT; `hist`, `len` and counters are 0.
- **Reset mid-frame:** the frame is abandoned immediately, with no `frameDone` and no partial `outValid` after reset release.

## Timing
- Every output is a flop; there are no combinational paths from `serIn` to outputs.
- The last pattern bit is sampled at edge E0. Length bits are sampled at E1..E_LEN_W.
- Payload bit k (1-based) is sampled at edge E_(LEN_W+k). `serOut`/`outValid` for bit k are visible during the cycle after that edge, giving one-cycle latency.
- `outValid` stays high for exactly `len` contiguous cycles with no gaps.
- `frameDone` is high with the last of those cycles.
- `lenErr` is high during the cycle after E_LEN_W.
- `busy` rises in the cycle after E0. It falls in the cycle after the final payload edge, or the cycle after E_LEN_W when length = 0.
- Back-to-back frames: the minimum gap between `frameDone` and the next first `outValid` is PAT_W+LEN_W cycles.

## Structure
- Package `serial_frame_pkg`:
  - `typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} frame_state_t`
  - helper function `max_len(LEN_W)`
- Sub-module `pattern_detector`, parametrised by PAT_W/PATTERN.
  - Inputs: `clk`, `rst`, `en`, `clr`, `serIn`. Output: combinational `match`.
  - Instantiated once.
- Top level holds the FSM, the length shift register and the down-counter.

## Test plan
All scenarios use PAT_W=4, PATTERN=1101, LEN_W=3.
- **Basic frame:** serIn 1,1,0,1, 0,1,1, 1,0,1 -> `outValid` high 3 cycles, `serOut` 1,0,1, `frameDone` with the third, `busy` low afterwards.
- **Overlap:** 1,1,1,0,1, 0,0,1, 0 -> match on the 5th bit; one payload bit 0 forwarded; `frameDone` with it.
- **Zero length:** 1,1,0,1, 0,0,0 -> `lenErr` single pulse, no `outValid`, back to HUNT. A following 1,1,0,1,0,0,1,1 forwards 1.
- **Maximum length with embedded pattern:** 1,1,0,1, 1,1,1, then payload 1,1,0,1,1,0,1 -> all 7 bits forwarded in order and the embedded 1101 is not re-detected. Also run with PATTERN=4'b0101: a post-frame 1,0,1 with the cleared `hist` matches on its 3rd bit, per the leading-zero exception.
- **Reset mid-payload:** drop `rst` asynchronously after 2 of 5 payload bits -> all outputs 0 immediately. Post-release, a fresh 1101 is needed; a stale tail produces no `outValid`.
- **Back-to-back frames:** two frames with the second pattern starting on the edge after the first frame's last payload bit -> both forwarded and the gap equals 7 cycles.
